// File: rtl/blink_sched.sv
// blink_sched: three-channel millisecond blink scheduler with one shared
// prescaler and per-channel pending reconfiguration applied at period end.
module blink_sched #(
    parameter int F_CLK_HZ = 25_000_000,
    parameter int MS_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [1:0]      cfg_ch,
    input  logic [MS_W-1:0] cfg_on_ms,
    input  logic [MS_W-1:0] cfg_off_ms,
    output logic            cfg_err,
    output logic            busy,
    output logic            led,
    output logic [8:0]      q
);
    localparam int PRESC = F_CLK_HZ / 1000;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESC - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [MS_W-1:0] on_ms    [3];
    logic [MS_W-1:0] off_ms   [3];
    logic [MS_W-1:0] pend_on  [3];
    logic [MS_W-1:0] pend_off [3];
    logic [MS_W-1:0] ms_cnt   [3];
    logic [2:0]      step     [3];
    logic [2:0]      phase;
    logic [2:0]      pend;
    logic [3:0]      pend_x;
    logic [2:0]      halt;
    logic [2:0]      to_off;
    logic [2:0]      p_end;
    logic [2:0]      inc;
    logic            tick;
    logic            wr;

    assign busy      = (state == RUN);
    assign tick      = busy && !stop && (presc == PMAX);
    assign pend_x    = {1'b0, pend};
    assign cfg_ready = !busy || (cfg_ch == 2'd3) || !pend_x[cfg_ch];
    assign wr        = cfg_valid && cfg_ready;
    assign q         = {step[0], step[1], step[2]};

    // Per-channel tick decode: advance, switch to OFF, or end the period
    always_comb begin
        halt   = '0;
        to_off = '0;
        p_end  = '0;
        inc    = '0;
        for (int i = 0; i < 3; i++) begin
            halt[i] = (on_ms[i] == '0) && (off_ms[i] == '0);
            if (tick && !halt[i]) begin
                if (phase[i]) begin
                    if (ms_cnt[i] == on_ms[i] - MS_W'(1)) begin
                        if (off_ms[i] == '0) p_end[i] = 1'b1;
                        else                 to_off[i] = 1'b1;
                    end else begin
                        inc[i] = 1'b1;
                    end
                end else if (ms_cnt[i] == off_ms[i] - MS_W'(1)) begin
                    p_end[i] = 1'b1;
                end else begin
                    inc[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            led       <= 1'b0;
            cfg_err   <= 1'b0;
            phase     <= '0;
            pend      <= '0;
            on_ms[0]  <= MS_W'(500);
            off_ms[0] <= MS_W'(500);
            on_ms[1]  <= MS_W'(250);
            off_ms[1] <= MS_W'(250);
            on_ms[2]  <= MS_W'(1000);
            off_ms[2] <= MS_W'(1000);
            for (int i = 0; i < 3; i++) begin
                ms_cnt[i]   <= '0;
                step[i]     <= '0;
                pend_on[i]  <= '0;
                pend_off[i] <= '0;
            end
        end else begin
            cfg_err <= wr && (cfg_ch == 2'd3);
            led     <= busy && !stop && phase[0] && (on_ms[0] != '0);
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (start && !stop) begin
                        state <= RUN;
                        for (int i = 0; i < 3; i++) begin
                            ms_cnt[i] <= '0;
                            step[i]   <= '0;
                            phase[i]  <= (on_ms[i] != '0);
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        presc <= '0;
                        pend  <= '0;
                        for (int i = 0; i < 3; i++) begin
                            if (pend[i]) begin
                                on_ms[i]  <= pend_on[i];
                                off_ms[i] <= pend_off[i];
                            end
                        end
                    end else begin
                        presc <= (presc == PMAX) ? '0 : presc + PW'(1);
                        for (int i = 0; i < 3; i++) begin
                            if (inc[i]) begin
                                ms_cnt[i] <= ms_cnt[i] + MS_W'(1);
                            end else if (to_off[i]) begin
                                ms_cnt[i] <= '0;
                                phase[i]  <= 1'b0;
                            end else if (p_end[i]) begin
                                ms_cnt[i] <= '0;
                                step[i]   <= step[i] + 3'd1;
                                if (pend[i]) begin
                                    on_ms[i]  <= pend_on[i];
                                    off_ms[i] <= pend_off[i];
                                    pend[i]   <= 1'b0;
                                    phase[i]  <= (pend_on[i] != '0);
                                end else begin
                                    phase[i]  <= (on_ms[i] != '0);
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A write landing on a period end becomes the next pending value
            for (int i = 0; i < 3; i++) begin
                if (wr && cfg_ch == 2'(i)) begin
                    if (!busy || stop) begin
                        on_ms[i]  <= cfg_on_ms;
                        off_ms[i] <= cfg_off_ms;
                    end else begin
                        pend_on[i]  <= cfg_on_ms;
                        pend_off[i] <= cfg_off_ms;
                        pend[i]     <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/blink_sched.md
BLINK_SCHED -- requirements
Module: blink_sched

Interface
REQ-001 Parameter F_CLK_HZ, default 25_000_000, clock frequency in Hz; SHALL be >= 1000.
REQ-002 Parameter MS_W, default 16, width of the on/off time fields in ms.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  level-sampled; IDLE->RUN request.
REQ-006 stop  in  1  level-sampled; RUN->IDLE request.
REQ-007 cfg_valid  in  1  configuration write request.
REQ-008 cfg_ready  out  1  configuration write can be accepted; combinational from state and cfg_ch.
REQ-009 cfg_ch  in  2  target channel: 0, 1 or 2; value 3 is invalid.
REQ-010 cfg_on_ms  in  MS_W  ON time in ms.
REQ-011 cfg_off_ms  in  MS_W  OFF time in ms.
REQ-012 cfg_err  out  1  one-cycle pulse: accepted write targeted cfg_ch=3.
REQ-013 busy  out  1  high in RUN.
REQ-014 led  out  1  channel 0 waveform.
REQ-015 q  out  9  step counters: q[8:6]=ch0, q[5:3]=ch1, q[2:0]=ch2.

Function
REQ-016 The block SHALL contain one shared prescaler: PRESC = F_CLK_HZ/1000 (integer division); it SHALL emit a one-cycle ms tick every PRESC cycles in RUN and be held at 0 in IDLE.
REQ-017 The FSM SHALL have two states: IDLE and RUN. IDLE->RUN when start=1 and stop=0. RUN->IDLE when stop=1. start in RUN SHALL be ignored. start and stop both high: stop wins.
REQ-018 Each channel SHALL hold active on_ms/off_ms, a phase (ON/OFF), an MS_W-bit ms counter and a 3-bit step counter.
REQ-019 On IDLE->RUN: prescaler, ms counters and step counters SHALL be cleared. Each phase SHALL be set to ON if on_ms != 0, else OFF.
REQ-020 On each tick in phase ON: if ms_cnt == on_ms-1, clear ms_cnt. Then go to OFF, or, when off_ms == 0, end the period. Otherwise increment ms_cnt.
REQ-021 On each tick in phase OFF: if ms_cnt == off_ms-1, clear ms_cnt and end the period. Otherwise increment ms_cnt.
REQ-022 Period end SHALL do the following in the same cycle: increment the step counter (3-bit wrap 7->0); apply that channel's pending config if present; set phase to ON if the (new) on_ms != 0, else OFF.
REQ-023 A channel with on_ms=0 and off_ms=0 SHALL be halted: wave 0, ms_cnt and step frozen.
REQ-024 Channel wave = RUN and phase==ON and on_ms != 0. led SHALL equal the ch0 wave, registered, so it is valid the cycle after the state change.
REQ-025 A config write is accepted when cfg_valid=1 and cfg_ready=1.
REQ-026 In IDLE, cfg_ready SHALL be 1, and an accepted write SHALL update that channel's active values in the next cycle.
REQ-027 In RUN, cfg_ready SHALL be 0 iff cfg_ch is 0..2 and that channel's pending flag is set. An accepted write SHALL load the pending registers and set the pending flag. The flag SHALL clear at the channel's next period end, when the values are applied (REQ-022).
REQ-028 An accepted write with cfg_ch=3 SHALL change no state and SHALL pulse cfg_err for one cycle starting the next cycle.
REQ-029 On RUN->IDLE: led and busy SHALL be 0 next cycle; q SHALL hold its value; pending configs SHALL be applied to the active values.
REQ-030 A period end and an accepted write to the same channel in the same cycle: the period end consumes the old pending value, and the new write becomes pending.

Reset
REQ-031 rst=1 SHALL take precedence over all inputs.
REQ-032 rst=1 SHALL put the FSM in IDLE; busy=0, led=0, q=0, cfg_err=0; all pending flags and counters cleared.
REQ-033 rst=1 SHALL restore default configs: ch0 500/500, ch1 250/250, ch2 1000/1000 ms.
REQ-034 Reset asserted mid-RUN SHALL give the REQ-032/REQ-033 state on the next cycle.

Verification (F_CLK_HZ=4000, so PRESC=4)
REQ-035 In IDLE, write ch0 2/2; start pulse at cycle 0 -> led=1 for cycles 1..8 and 0 for cycles 9..16; q[8:6] goes 0->1 at the period end (16 cycles after start); the pattern repeats.
REQ-036 In RUN, write ch1 1/1 while ch1 has pending set -> cfg_ready=0 for cfg_ch=1 and 1 for cfg_ch=0; the new timing takes effect only after the next ch1 step increment.
REQ-037 ch2 0/0 in RUN -> q[2:0] frozen and no waveform. ch0 3/0 -> led constantly 1, q[8:6] increments every 12 cycles. Run 8 periods -> q[8:6] wraps 7->0.
REQ-038 start and stop both high in IDLE -> stays IDLE. stop in RUN -> busy=0 and led=0 next cycle, q held. start again -> q=0.
REQ-039 Write with cfg_ch=3 -> cfg_err high for exactly one cycle, no config change. rst mid-RUN -> all outputs 0 and default periods restored.
